inst_mem_dispatch: RTL
======================

Name: inst_mem_dispatch

Overview:
Receiving end of the 27-bit instruction bus (inst/inst_valid) that the top-level controller is driven with. It buffers incoming instructions in a small FIFO and decodes them. Memory-burst opcodes are expanded into per-cycle address/enable beats toward the data-memory banks. All other opcodes are forwarded to the compute engine over a valid/ready handshake.

Parameters:
INST_WIDTH, 27, instruction word width; fields {opcode[26:24], addr[23:12], length[11:6], port[5:4], rsvd[3:0]}
ADDR_WIDTH, 12, memory address width; must equal the addr field width
FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock; one clock domain
rst  in  1  reset: one clock; reset is synchronous and active-high
inst  in  INST_WIDTH  instruction word, sampled when inst_valid=1
inst_valid  in  1  single-cycle strobe; upstream does not wait for ready
inst_ready  out  1  FIFO not full (combinational from FIFO count)
drop_err  out  1  sticky: an instruction arrived while the FIFO was full
mem_en  out  1  memory beat strobe
mem_we  out  1  1 = write beat (opcode 001), 0 = read beat (opcode 000)
mem_addr  out  ADDR_WIDTH  beat address
mem_port  out  2  target bank for the beat
exec_valid  out  1  non-memory instruction offered to the compute engine
exec_inst  out  INST_WIDTH  forwarded instruction word, stable while exec_valid=1
exec_ready  in  1  compute engine accepts
busy  out  1  FSM not IDLE, or FIFO not empty
done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (rst=1 at a clock edge): FIFO emptied and FSM to IDLE. All outputs are 0 except inst_ready=1. drop_err is cleared. Reset mid-burst or mid-exec aborts immediately; no done pulse is issued.
- Push: on an edge with inst_valid=1 and FIFO not full, write the word. Push while full: drop the word and set drop_err (sticky until rst). A pop on the same edge does not rescue a push into a full FIFO.
- Field decode: opcode=inst[26:24], addr=[23:12], length=[11:6], port=[5:4]. Bits [3:0] are ignored.
- FSM states: IDLE, BURST, EXEC, DONE.
- IDLE:
  - If the FIFO is non-empty, pop the head and latch its fields.
  - opcode 000/001 with length!=0 -> BURST.
  - opcode 000/001 with length==0 -> DONE.
  - other opcodes -> EXEC.
- BURST: one beat per cycle for exactly length beats (1..63).
  - Beat k drives mem_en=1, mem_addr=(addr+k) mod 2^ADDR_WIDTH, mem_port=port, mem_we=(opcode==001).
  - The address wraps from 4095 to 0 with no error.
  - After the last beat -> DONE.
- EXEC: exec_valid=1 with exec_inst equal to the popped word.
  - Hold both until a cycle with exec_ready=1, then -> DONE.
  - exec_ready with exec_valid=0 is ignored.
- DONE: done=1 for one cycle, then -> IDLE. Next pop no earlier than the following IDLE cycle.
- Latency: instruction pushed at edge T -> popped at edge T+1 -> first mem_en (or exec_valid) high during the cycle after edge T+2. done pulses the cycle after the last beat.
- Back-to-back: two instructions have a 2-cycle gap (DONE, IDLE) between the last beat of one and the first beat of the next.
- mem_addr/mem_port/mem_we are 0 whenever mem_en=0. exec_inst is 0 whenever exec_valid=0.
- busy=0 only when the FSM is in IDLE and the FIFO is empty.

Decomposition:
- Shared package inst_pkg holds:
  - opcode constants OP_LOAD=3'b000, OP_STORE=3'b001.
  - Field bit-position localparams.
  - A packed struct inst_t {opcode, addr, length, port, rsvd}.
  - FSM state enum.
- One sub-module, inst_fifo: synchronous FIFO with DEPTH, WIDTH, push/pop, full/empty. The dispatcher FSM and address counter stay in inst_mem_dispatch.

Test Plan:
- Load burst: after reset, inst = {000, addr 100, len 4, port 0}, one-cycle valid -> mem_en high 4 consecutive cycles, mem_addr 100,101,102,103, mem_we=0, mem_port=0. done pulses once, the cycle after addr 103.
- Back-to-back: load {addr 200, len 2, port 2} then store {addr 4094, len 3, port 1} on consecutive cycles -> reads at 200,201 on port 2. Then 2 idle cycles. Then writes at 4094, 4095, 0 (wrap) with mem_we=1 on port 1. Two done pulses.
- Overflow: 6 pushes on 6 consecutive cycles, each a 63-beat load -> entries 1..5 accepted (one popped early, four fill the FIFO). The 6th is dropped: inst_ready=0 that cycle, drop_err=1 and held. The 5 bursts complete in order.
- Exec handshake: opcode 100 word 0x4ABCDEF; hold exec_ready=0 for 5 cycles, then 1 -> exec_valid high for 6 cycles with exec_inst stable, then done one cycle later. No mem_en at any point.
- Zero length: load with length 0 -> no mem_en. done pulses the cycle after pop.
- Reset mid-burst: rst=1 at beat 2 of a 10-beat load with 2 entries queued -> next cycle mem_en=0, busy=0, FIFO empty, drop_err=0, no done pulse. A new load after reset behaves exactly as in the load-burst scenario.

Source files
------------

// File: rtl/inst_pkg.sv
// inst_pkg: shared instruction field layout, opcodes and dispatcher state encoding.
package inst_pkg;
    localparam int OP_MSB   = 26;
    localparam int OP_LSB   = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 12;
    localparam int LEN_MSB  = 11;
    localparam int LEN_LSB  = 6;
    localparam int PORT_MSB = 5;
    localparam int PORT_LSB = 4;
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]     opcode;
        logic [ADDR_MSB-ADDR_LSB:0] addr;
        logic [LEN_MSB-LEN_LSB:0]   length;
        logic [PORT_MSB-PORT_LSB:0] port;
        logic [3:0]                 rsvd;
    } inst_t;
    typedef enum logic [1:0] {IDLE, BURST, EXEC, DONE} state_t;
    function automatic logic is_mem(input logic [2:0] op);
        return op == OP_LOAD || op == OP_STORE;
    endfunction
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO; a push into a full FIFO is ignored even if a pop happens on the same edge.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/inst_mem_dispatch.sv
// inst_mem_dispatch: buffers instructions, expands load/store into memory beats and
// hands every other opcode to the compute engine.
module inst_mem_dispatch import inst_pkg::*; #(
    parameter int INST_WIDTH = 27,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    output logic                  drop_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_port,
    output logic                  exec_valid,
    output logic [INST_WIDTH-1:0] exec_inst,
    input  logic                  exec_ready,
    output logic                  busy,
    output logic                  done
);
    logic [INST_WIDTH-1:0] head_raw;
    logic full, empty, pop;
    inst_t head, cur;
    state_t state;
    logic [5:0] cnt;
    assign head = inst_t'(head_raw);
    assign pop = state == IDLE && !empty;
    assign inst_ready = !full;
    assign busy = state != IDLE || !empty;
    inst_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INST_WIDTH)) u_fifo (
        .clk(clk), .rst(rst), .push(inst_valid), .din(inst), .pop(pop),
        .dout(head_raw), .full(full), .empty(empty)
    );
    // Memory-beat outputs default to zero each cycle so they read 0 whenever mem_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur <= '0;
            cnt <= '0;
            drop_err <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_port <= '0;
            exec_valid <= 1'b0;
            exec_inst <= '0;
            done <= 1'b0;
        end else begin
            drop_err <= drop_err | (inst_valid & full);
            done <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_port <= '0;
            case (state)
                IDLE: if (!empty) begin
                    cur <= head;
                    cnt <= '0;
                    state <= !is_mem(head.opcode) ? EXEC : head.length == '0 ? DONE : BURST;
                end
                BURST: begin
                    mem_en <= 1'b1;
                    mem_we <= cur.opcode == OP_STORE;
                    mem_addr <= cur.addr + ADDR_WIDTH'(cnt);
                    mem_port <= cur.port;
                    cnt <= cnt + 6'd1;
                    if (cnt == cur.length - 6'd1) state <= DONE;
                end
                EXEC: if (exec_valid && exec_ready) begin
                    exec_valid <= 1'b0;
                    exec_inst <= '0;
                    state <= DONE;
                end else begin
                    exec_valid <= 1'b1;
                    exec_inst <= INST_WIDTH'(cur);
                end
                DONE: begin
                    done <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
